display_swap_scheduler: RTL
===========================

// Module: display_swap_scheduler
// PURPOSE
// Sequences framebuffer swaps into the display framebuffer reader. Buffers one swap request from
// the renderer and issues it on the reader's swap_fb/fb_addr/fb_swapped handshake. A new frame is
// only issued after the previous frame has fully left the display stream (tlast beat seen).
// Sits between the renderer's swap command and the framebuffer reader.
// PARAMETERS
// ADDR_WIDTH       32        framebuffer address width
// CNT_WIDTH        16        width of frame_count
// REFRESH_CYCLES   1000000   idle cycles before auto re-issue (DISPLAY_AUTO_REFRESH_EN only)
// PORTS
// aclk             in   1           clock
// resetn           in   1           asynchronous active-low reset
// s_swap_valid     in   1           swap request valid
// s_swap_ready     out  1           swap request ready (pending slot empty)
// s_swap_addr      in   ADDR_WIDTH  framebuffer base address of request
// swap_fb          out  1           swap request to framebuffer reader
// fb_addr          out  ADDR_WIDTH  address to framebuffer reader
// fb_swapped       in   1           reader ack; idles 1, drops to 0 on start, returns 1 when address taken
// disp_tvalid      in   1           monitor tap: reader display stream tvalid
// disp_tready      in   1           monitor tap: reader display stream tready
// disp_tlast       in   1           monitor tap: reader display stream tlast
// busy             out  1           state != IDLE
// frame_done       out  1           one-cycle pulse: frame fully streamed
// frame_count      out  CNT_WIDTH   frames completed, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, pending_valid=0, swap_fb=0, fb_addr=0,
//   busy=0, frame_done=0, frame_count=0; s_swap_ready=!pending_valid (=1).
// - Pending slot: 1 entry; accept on s_swap_valid&&s_swap_ready -> pending_valid=1, addr latched.
//   Cleared on IDLE->REQ transition; no accept while full (no overwrite, no bypass).
// - IDLE: if pending_valid -> fb_addr<=pending addr, swap_fb<=1, -> REQ.
//   Latency: request accepted at edge N, swap_fb high after edge N+1.
// - REQ: hold swap_fb=1 and fb_addr; on fb_swapped==0 -> swap_fb<=0, -> ACK.
// - ACK: hold fb_addr stable (reader samples it here); on fb_swapped==1 -> STREAM.
// - STREAM: on disp_tvalid&&disp_tready&&disp_tlast -> frame_done=1 for one cycle,
//   frame_count+=1, -> IDLE. A new pending request is accepted during REQ/ACK/STREAM but
//   issued only from IDLE.
// - Taps are monitor-only; beats outside STREAM are ignored; tlast without tvalid&&tready
//   is ignored.
// - fb_swapped==0 while in IDLE (foreign activity): IDLE does not issue until fb_swapped==1.
// - Reset mid-operation discards the pending request and in-flight state; the reader frame
//   already started is not tracked and its tlast is ignored (the state is IDLE).
// - 2-bit state encoding IDLE=0, REQ=1, ACK=2, STREAM=3; no illegal states.
// CONFIGURATION
// - DISPLAY_AUTO_REFRESH_EN defined: in IDLE with no pending request and at least one frame
//   shown since reset, a counter counts cycles; at REFRESH_CYCLES, re-issue the last fb_addr
//   (IDLE->REQ), counter cleared. Counter clears on any leave of IDLE. A pending request takes
//   priority in the same cycle. Refresh frames pulse frame_done and increment frame_count.
// - Not defined: no counter is built and IDLE waits for a request indefinitely;
//   REFRESH_CYCLES is unused.
// TESTING
// - Reset, then swap 0x1000_0000; reader model acks 3 cycles later -> swap_fb high 1 cycle
//   after accept, fb_addr=0x1000_0000 until fb_swapped=1, frame_done after tlast,
//   frame_count=1.
// - Second swap 0x2000_0000 sent mid-STREAM -> accepted, s_swap_ready=0, swap_fb stays low
//   until first tlast, then issued; third request stalls until pending clears.
// - tlast with tready=0 in STREAM -> no frame_done; tlast beats in IDLE -> no count change.
// - Assert resetn=0 in ACK -> all outputs at reset values immediately (async), pending dropped.
// - frame_count at 0xFFFF plus one frame -> 0x0000.
// - DISPLAY_AUTO_REFRESH_EN, REFRESH_CYCLES=16: after frame 0x1000_0000, idle 16 cycles ->
//   re-issue 0x1000_0000; a request at cycle 16 instead issues its own address.

Source files
------------

// File: rtl/display_swap_scheduler.sv
// Buffers one renderer swap and issues it to the framebuffer reader. Issue is one cycle after accept, and a new frame starts only after tlast.
// s_swap_ready is low while the pending slot is full. Define DISPLAY_AUTO_REFRESH_EN to re-issue the last frame after REFRESH_CYCLES of idle.
module display_swap_scheduler #(
  parameter int ADDR_WIDTH     = 32,
  parameter int CNT_WIDTH      = 16,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s_swap_valid,
  output logic                  s_swap_ready,
  input  logic [ADDR_WIDTH-1:0] s_swap_addr,
  output logic                  swap_fb,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic                  fb_swapped,
  input  logic                  disp_tvalid,
  input  logic                  disp_tready,
  input  logic                  disp_tlast,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACK    = 2'd2,
    STREAM = 2'd3
  } state_t;

  state_t                  state, state_nxt;
  logic                    pending_valid, pending_valid_nxt;
  logic [ADDR_WIDTH-1:0]   pending_addr, pending_addr_nxt;
  logic                    swap_fb_nxt;
  logic [ADDR_WIDTH-1:0]   fb_addr_nxt;
  logic                    frame_done_nxt;
  logic [CNT_WIDTH-1:0]    frame_count_nxt;
  logic                    accept;
  logic                    last_beat;
  logic                    refresh_fire;

  assign s_swap_ready = !pending_valid;
  assign busy         = (state != IDLE);
  assign accept       = s_swap_valid && s_swap_ready;
  assign last_beat    = disp_tvalid && disp_tready && disp_tlast;

`ifdef DISPLAY_AUTO_REFRESH_EN
  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic          shown;
  logic          counting;
  logic [RW-1:0] refresh_cnt;

  // A request arriving in the firing cycle wins: the refresh is suppressed and the new address issues next.
  assign counting     = (state == IDLE) && !pending_valid && shown;
  assign refresh_fire = counting && (refresh_cnt == RW'(REFRESH_CYCLES - 1)) && fb_swapped && !accept;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      shown       <= 1'b0;
      refresh_cnt <= '0;
    end else begin
      if (frame_done_nxt)
        shown <= 1'b1;
      if (!counting || refresh_fire)
        refresh_cnt <= '0;
      else if (refresh_cnt != RW'(REFRESH_CYCLES - 1))
        refresh_cnt <= refresh_cnt + 1'b1;
    end
  end
`else
  assign refresh_fire = 1'b0;
`endif

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      pending_valid <= 1'b0;
      pending_addr  <= '0;
      swap_fb       <= 1'b0;
      fb_addr       <= '0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      state         <= state_nxt;
      pending_valid <= pending_valid_nxt;
      pending_addr  <= pending_addr_nxt;
      swap_fb       <= swap_fb_nxt;
      fb_addr       <= fb_addr_nxt;
      frame_done    <= frame_done_nxt;
      frame_count   <= frame_count_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    pending_valid_nxt = pending_valid;
    pending_addr_nxt  = pending_addr;
    swap_fb_nxt       = swap_fb;
    fb_addr_nxt       = fb_addr;
    frame_done_nxt    = 1'b0;
    frame_count_nxt   = frame_count;

    if (accept) begin
      pending_valid_nxt = 1'b1;
      pending_addr_nxt  = s_swap_addr;
    end

    case (state)
      IDLE: begin
        // fb_swapped low here means the reader is busy with someone else's request.
        if (pending_valid && fb_swapped) begin
          fb_addr_nxt       = pending_addr;
          swap_fb_nxt       = 1'b1;
          pending_valid_nxt = 1'b0;
          state_nxt         = REQ;
        end else if (refresh_fire) begin
          swap_fb_nxt = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        if (!fb_swapped) begin
          swap_fb_nxt = 1'b0;
          state_nxt   = ACK;
        end
      end
      ACK: begin
        if (fb_swapped)
          state_nxt = STREAM;
      end
      STREAM: begin
        if (last_beat) begin
          frame_done_nxt  = 1'b1;
          frame_count_nxt = frame_count + 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
